// File: rtl/accel_pkg.sv
// accel_pkg: shared sizes, FSM state codes and int8 saturation for the systolic matmul accelerator
package accel_pkg;
  localparam int N = 16;
  localparam int DW = 8;
  localparam int AW = 13;
  localparam int ACCW = 32;
  localparam int SHIFT = 7;
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD_I = 3'd1, GAP = 3'd2, LOAD_W = 3'd3,
    FETCH_W = 3'd4, COMPUTE = 3'd5, WRITEBACK = 3'd6, DONE = 3'd7
  } state_t;
  function automatic logic [DW-1:0] sat8(input logic signed [ACCW-1:0] v);
    return v > 32'sd127 ? 8'h7f : v < -32'sd128 ? 8'h80 : v[DW-1:0];
  endfunction
endpackage

// File: rtl/accel_pe.sv
// accel_pe: weight-stationary MAC cell (clk/rst/en stall, w_ld loads weight, activation passes right, partial sum passes down)
module accel_pe
  import accel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   w_ld,
  input  logic signed [DW-1:0]   w_in,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [ACCW-1:0] s_in,
  output logic signed [DW-1:0]   a_out,
  output logic signed [ACCW-1:0] s_out
);
  logic signed [DW-1:0] w;
  logic signed [2*DW-1:0] p;
  assign p = (2*DW)'(a_in) * (2*DW)'(w);
  always_ff @(posedge clk)
    if (rst) begin
      w <= '0;
      a_out <= '0;
      s_out <= '0;
    end else if (en) begin
      if (w_ld) w <= w_in;
      a_out <= a_in;
      s_out <= s_in + ACCW'(p);
    end
endmodule

// File: rtl/systolic_accel_top.sv
// systolic_accel_top: int8 16x16 systolic matmul; streams A then W into SRAM, computes A x W, writes requantised rows to OADDR (out_valid/out_addr/out_data mirror writes, STATE = FSM code)
module systolic_accel_top
  import accel_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  input  logic [N*DW-1:0] input_data,
  input  logic [AW-1:0]   IADDR,
  input  logic [AW-1:0]   WADDR,
  input  logic [AW-1:0]   OADDR,
  output logic [5:0]      STATE,
  output logic            out_valid,
  output logic [AW-1:0]   out_addr,
  output logic [N*DW-1:0] out_data
);
  state_t st;
  logic [5:0] cnt, lim;
  logic [AW-1:0] ia, wa, oa, raddr;
  logic [N*DW-1:0] rdata;
  logic [N*DW-1:0] mem [2**AW];
  logic [N*DW-1:0] res [N];
  logic [DW-1:0] a_h [N][N+1];
  logic [ACCW-1:0] s_v [N+1][N];
  assign STATE = {3'b0, st};
  // The flush cycle of FETCH_W prefetches A row 0 so COMPUTE cycle c sees row c in rdata.
  always_comb begin
    lim = st == FETCH_W ? 6'd16 : st == COMPUTE ? 6'd46 : 6'd15;
    raddr = st == FETCH_W ? (cnt == 6'd16 ? ia : wa + AW'(cnt)) : ia + AW'(cnt + 6'd1);
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      st <= IDLE;
      cnt <= '0;
      ia <= '0;
      wa <= '0;
      oa <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (EN && st != DONE) begin
      if (st == IDLE || st == GAP || cnt == lim) begin
        st <= state_t'(st + 3'd1);
        cnt <= '0;
      end else cnt <= cnt + 6'd1;
      if (st == IDLE) begin
        ia <= IADDR;
        wa <= WADDR;
        oa <= OADDR;
      end
      out_valid <= (st == COMPUTE && cnt == lim) || (st == WRITEBACK && cnt != lim);
      out_addr <= st == WRITEBACK ? out_addr + AW'(1) : oa;
      out_data <= res[st == WRITEBACK ? 4'(cnt + 6'd1) : 4'd0];
    end
  always_ff @(posedge CLK) begin
    if (EN && !RESET && (st == LOAD_I || st == LOAD_W)) mem[(st == LOAD_I ? ia : wa) + AW'(cnt)] <= input_data;
    if (EN && !RESET && out_valid) mem[out_addr] <= out_data;
    if (EN) rdata <= mem[raddr];
  end
  // Lane k is delayed k cycles so A[i][k] reaches PE row k at COMPUTE cycle i+k.
  for (genvar k = 0; k < N; k++) begin : g_skew
    if (k == 0) begin : g_direct
      assign a_h[0][0] = rdata[DW-1:0];
    end else begin : g_delay
      logic [DW-1:0] d [k];
      always_ff @(posedge CLK)
        if (RESET) d <= '{default: '0};
        else if (EN) begin
          d[0] <= rdata[k*DW +: DW];
          for (int m = 1; m < k; m++) d[m] <= d[m-1];
        end
      assign a_h[k][0] = d[k-1];
    end
  end
  for (genvar c = 0; c < N; c++) begin : g_top
    assign s_v[0][c] = '0;
  end
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      accel_pe u_pe (
        .clk(CLK),
        .rst(RESET),
        .en(EN),
        .w_ld(st == FETCH_W && cnt == 6'(r + 1)),
        .w_in(rdata[c*DW +: DW]),
        .a_in(a_h[r][c]),
        .s_in(s_v[r][c]),
        .a_out(a_h[r][c+1]),
        .s_out(s_v[r+1][c])
      );
    end
  end
  // Column j emits O[i][j] at COMPUTE cycle i+j+N; deskew into row buffers.
  always_ff @(posedge CLK)
    if (RESET) res <= '{default: '0};
    else if (EN && st == COMPUTE)
      for (int j = 0; j < N; j++)
        if (cnt >= 6'(N + j) && cnt < 6'(2*N + j))
          res[4'(cnt - 6'(N + j))][j*DW +: DW] <= sat8($signed(s_v[N][j]) >>> SHIFT);
endmodule

// File: tb/tb_systolic_accel_top.sv
// tb_systolic_accel_top: scoreboard bench for systolic_accel_top
module tb_systolic_accel_top;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic EN = 1'b0;
  logic [127:0] input_data = '0;
  logic [12:0] IADDR = '0, WADDR = '0, OADDR = '0;
  logic [5:0] STATE;
  logic out_valid;
  logic [12:0] out_addr;
  logic [127:0] out_data;
  typedef struct packed {
    logic [12:0]  a;
    logic [127:0] d;
  } exp_t;
  exp_t exp_q [$];
  exp_t e;
  logic [127:0] am [16], wm [16], er [16];
  int errors = 0, checks = 0;

  systolic_accel_top dut (
    .CLK(CLK),
    .RESET(RESET),
    .EN(EN),
    .input_data(input_data),
    .IADDR(IADDR),
    .WADDR(WADDR),
    .OADDR(OADDR),
    .STATE(STATE),
    .out_valid(out_valid),
    .out_addr(out_addr),
    .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [127:0] model_row(input int i);
    logic [127:0] r;
    int s;
    for (int j = 0; j < 16; j++) begin
      s = 0;
      for (int k = 0; k < 16; k++)
        s += int'($signed(am[i][k*8 +: 8])) * int'($signed(wm[k][j*8 +: 8]));
      s = s >>> 7;
      r[j*8 +: 8] = s > 127 ? 8'h7f : s < -128 ? 8'h80 : s[7:0];
    end
    return r;
  endfunction

  task automatic use_model();
    for (int i = 0; i < 16; i++) er[i] = model_row(i);
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] w, input logic [7:0] r);
    for (int i = 0; i < 16; i++) begin
      am[i] = {16{a}};
      wm[i] = {16{w}};
      er[i] = {16{r}};
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    EN = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_state", 128'(STATE), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_addr", 128'(out_addr), 128'(0));
    chk("rst_data", out_data, 128'(0));
  endtask

  task automatic run(input logic [12:0] ia, input logic [12:0] wa, input logic [12:0] oa,
                     input int stall_at, input int abort_at);
    IADDR = ia;
    WADDR = wa;
    OADDR = oa;
    EN = 1'b1;
    if (abort_at < 0)
      for (int i = 0; i < 16; i++) exp_q.push_back('{a: oa + 13'(i), d: er[i]});
    @(negedge CLK);
    IADDR = ~ia;
    WADDR = ~wa;
    OADDR = ~oa;
    for (int k = 0; k < 16; k++) begin
      chk("state_load_i", 128'(STATE), 128'(1));
      input_data = am[k];
      @(negedge CLK);
    end
    chk("state_gap", 128'(STATE), 128'(2));
    input_data = {4{32'hdeadbeef}};
    @(negedge CLK);
    for (int k = 0; k < 16; k++) begin
      chk("state_load_w", 128'(STATE), 128'(3));
      input_data = wm[k];
      @(negedge CLK);
    end
    input_data = {4{32'h5a5aa5a5}};
    for (int k = 0; k < 17; k++) begin
      chk("state_fetch_w", 128'(STATE), 128'(4));
      @(negedge CLK);
    end
    for (int c = 0; c < 47; c++) begin
      if (c == abort_at) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort_state", 128'(STATE), 128'(0));
        chk("abort_valid", 128'(out_valid), 128'(0));
        return;
      end
      if (c == stall_at) begin
        EN = 1'b0;
        repeat (5) begin
          @(negedge CLK);
          chk("stall_state", 128'(STATE), 128'(5));
          chk("stall_valid", 128'(out_valid), 128'(0));
        end
        EN = 1'b1;
      end
      chk("state_compute", 128'(STATE), 128'(5));
      @(negedge CLK);
    end
    for (int i = 0; i < 16; i++) begin
      chk("state_writeback", 128'(STATE), 128'(6));
      @(negedge CLK);
    end
    chk("state_done", 128'(STATE), 128'(7));
    chk("done_valid", 128'(out_valid), 128'(0));
    chk("rows_written", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLK);
        if (out_valid && EN) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h want no write", out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("wb_addr", 128'(out_addr), 128'(e.a));
            chk("wb_data", out_data, e.d);
          end
        end
      end
    join_none
    // identity-style weights: 64 on the diagonal, A = 2(i+k) -> row i byte k = i+k
    for (int i = 0; i < 16; i++) begin
      wm[i] = '0;
      wm[i][i*8 +: 8] = 8'd64;
      for (int k = 0; k < 16; k++) begin
        am[i][k*8 +: 8] = 8'(2 * (i + k));
        er[i][k*8 +: 8] = 8'(i + k);
      end
    end
    do_reset();
    run(13'd100, 13'd200, 13'd300, -1, -1);
    // uniform: 16*8*8 = 1024 >>> 7 = 8
    fill(8'h08, 8'h08, 8'h08);
    do_reset();
    run(13'd1000, 13'd2000, 13'd3000, -1, -1);
    // 16*127*127 >>> 7 = 2016 -> +127
    fill(8'h7f, 8'h7f, 8'h7f);
    do_reset();
    run(13'd50, 13'd70, 13'd90, -1, -1);
    // 16*(-128)*127 >>> 7 = -2032 -> -128
    fill(8'h80, 8'h7f, 8'h80);
    do_reset();
    run(13'd50, 13'd70, 13'd90, -1, -1);
    // mixed signed data; output overwrites the last weight word
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 16; k++) begin
        am[i][k*8 +: 8] = 8'(i * 7 - k * 9);
        wm[i][k*8 +: 8] = 8'((i * 5 + k * 3) % 17 - 8);
      end
    use_model();
    do_reset();
    run(13'd0, 13'd16, 13'd31, -1, -1);
    // same run with a 5-cycle stall mid-COMPUTE
    do_reset();
    run(13'd0, 13'd16, 13'd31, 20, -1);
    // abort at COMPUTE cycle 10, then a fresh run with wrapping activation region
    fill(8'h11, 8'h22, 8'h00);
    do_reset();
    run(13'd0, 13'd16, 13'd31, -1, 10);
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 16; k++) begin
        am[i][k*8 +: 8] = 8'((i + 1) * (k + 3) - 40);
        wm[i][k*8 +: 8] = i == k ? 8'd100 : 8'(i - k);
      end
    use_model();
    run(13'd8190, 13'd500, 13'd4000, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
